// File: rtl/msk_share_codec_if.sv
// Host / PRNG / core bundle for the masking codec. The slave side is the codec;
// the master side is whatever drives it (host, PRNG and core together).
interface msk_share_codec_if #(
  parameter int d     = 2,
  parameter int RND_W = 256*(d-1)
);
  logic               in_valid;
  logic               in_ready;
  logic [127:0]       plaintext;
  logic [127:0]       key;
  logic               rnd_valid;
  logic               rnd_ready;
  logic [RND_W-1:0]   rnd;
  logic               core_valid_in;
  logic               core_ready;
  logic [128*d-1:0]   sh_plaintext;
  logic [128*d-1:0]   sh_key;
  logic               core_cipher_valid;
  logic [128*d-1:0]   sh_ciphertext;
  logic               out_valid;
  logic               out_ready;
  logic [127:0]       ciphertext;
  logic               busy;

  modport slave (
    input  in_valid, plaintext, key, rnd_valid, rnd, core_ready,
           core_cipher_valid, sh_ciphertext, out_ready,
    output in_ready, rnd_ready, core_valid_in, sh_plaintext, sh_key,
           out_valid, ciphertext, busy
  );

  modport master (
    output in_valid, plaintext, key, rnd_valid, rnd, core_ready,
           core_cipher_valid, sh_ciphertext, out_ready,
    input  in_ready, rnd_ready, core_valid_in, sh_plaintext, sh_key,
           out_valid, ciphertext, busy
  );
endinterface

// File: rtl/msk_share_codec.sv
// Boolean-masking boundary codec: splits host plaintext/key into d shares for the
// masked AES core and recombines the core's shared ciphertext for the host.
module msk_share_codec #(
  parameter int d     = 2,
  parameter int RND_W = 256*(d-1)
) (
  input logic               clk,
  input logic               nrst,
  msk_share_codec_if.slave  io
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_RND, S_SEND, S_RUN, S_OUT} state_e;

  state_e             state_q, state_d;
  logic [127:0]       pt_q, key_q, ct_q;
  logic [128*d-1:0]   shp_q, shk_q;
  logic [128*d-1:0]   shp_enc, shk_enc;
  logic [127:0]       ct_rec;
  logic               pacc, kacc, cacc;

  // Bit-major layout: share j of bit i lives at d*i+j; last share closes the XOR.
  always_comb begin
    shp_enc = '0;
    shk_enc = '0;
    pacc    = 1'b0;
    kacc    = 1'b0;
    for (int i = 0; i < 128; i++) begin
      pacc = pt_q[i];
      kacc = key_q[i];
      for (int j = 0; j < d-1; j++) begin
        shp_enc[d*i+j] = io.rnd[(d-1)*i+j];
        shk_enc[d*i+j] = io.rnd[128*(d-1)+(d-1)*i+j];
        pacc = pacc ^ io.rnd[(d-1)*i+j];
        kacc = kacc ^ io.rnd[128*(d-1)+(d-1)*i+j];
      end
      shp_enc[d*i+d-1] = pacc;
      shk_enc[d*i+d-1] = kacc;
    end
  end

  always_comb begin
    ct_rec = '0;
    cacc   = 1'b0;
    for (int i = 0; i < 128; i++) begin
      cacc = 1'b0;
      for (int j = 0; j < d; j++) cacc = cacc ^ io.sh_ciphertext[d*i+j];
      ct_rec[i] = cacc;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (io.in_valid)          state_d = S_WAIT_RND;
      S_WAIT_RND: if (io.rnd_valid)         state_d = S_SEND;
      S_SEND:     if (io.core_ready)        state_d = S_RUN;
      S_RUN:      if (io.core_cipher_valid) state_d = S_OUT;
      S_OUT:      if (io.out_ready)         state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io.in_ready      = 1'b0;
    io.rnd_ready     = 1'b0;
    io.core_valid_in = 1'b0;
    io.out_valid     = 1'b0;
    unique case (state_q)
      S_IDLE:     io.in_ready      = 1'b1;
      S_WAIT_RND: io.rnd_ready     = 1'b1;
      S_SEND:     io.core_valid_in = 1'b1;
      S_OUT:      io.out_valid     = 1'b1;
      default: ;
    endcase
    io.busy = (state_q != S_IDLE);
  end

  // Unmasked operands and shares are wiped as soon as they are handed on.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pt_q  <= '0;
      key_q <= '0;
      shp_q <= '0;
      shk_q <= '0;
      ct_q  <= '0;
    end else begin
      if (state_q == S_IDLE && io.in_valid) begin
        pt_q  <= io.plaintext;
        key_q <= io.key;
      end
      if (state_q == S_WAIT_RND && io.rnd_valid) begin
        shp_q <= shp_enc;
        shk_q <= shk_enc;
        pt_q  <= '0;
        key_q <= '0;
      end
      if (state_q == S_SEND && io.core_ready) begin
        shp_q <= '0;
        shk_q <= '0;
      end
      if (state_q == S_RUN && io.core_cipher_valid) ct_q <= ct_rec;
    end
  end

  assign io.sh_plaintext = shp_q;
  assign io.sh_key       = shk_q;
  assign io.ciphertext   = ct_q;
endmodule

// File: tb/tb_msk_share_codec.sv
// Directed vector bench for msk_share_codec with d=2.
module tb_msk_share_codec;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  msk_share_codec_if #(.d(2)) bus();
  msk_share_codec #(.d(2)) dut (.clk(clk), .nrst(nrst), .io(bus.slave));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] pt, key;
    logic [255:0] rnd;
    logic [127:0] pe, po, ke, ko, ct;
  } vec_t;
  vec_t vt[3];

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] evn(input logic [255:0] x);
    for (int i = 0; i < 128; i++) evn[i] = x[2*i];
  endfunction
  function automatic logic [127:0] odd(input logic [255:0] x);
    for (int i = 0; i < 128; i++) odd[i] = x[2*i+1];
  endfunction
  function automatic logic [255:0] ilv(input logic [127:0] s0, input logic [127:0] s1);
    for (int i = 0; i < 128; i++) begin
      ilv[2*i]   = s0[i];
      ilv[2*i+1] = s1[i];
    end
  endfunction
  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hs(input string tag, input logic ir, input logic rr,
                    input logic cv, input logic ov, input logic bz);
    chk({tag, ".in_ready"},      256'(bus.in_ready),      256'(ir));
    chk({tag, ".rnd_ready"},     256'(bus.rnd_ready),     256'(rr));
    chk({tag, ".core_valid_in"}, 256'(bus.core_valid_in), 256'(cv));
    chk({tag, ".out_valid"},     256'(bus.out_valid),     256'(ov));
    chk({tag, ".busy"},          256'(bus.busy),          256'(bz));
  endtask

  task automatic chk_shares(input string tag, input vec_t v);
    chk({tag, ".pt_even"},  256'(evn(bus.sh_plaintext)), 256'(v.pe));
    chk({tag, ".pt_odd"},   256'(odd(bus.sh_plaintext)), 256'(v.po));
    chk({tag, ".key_even"}, 256'(evn(bus.sh_key)),       256'(v.ke));
    chk({tag, ".key_odd"},  256'(odd(bus.sh_key)),       256'(v.ko));
  endtask

  task automatic do_reset(input string tag);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    hs({tag, ".rst"}, 1, 0, 0, 0, 0);
    chk({tag, ".rst_shp"}, bus.sh_plaintext, '0);
    chk({tag, ".rst_shk"}, bus.sh_key, '0);
    chk({tag, ".rst_ct"},  256'(bus.ciphertext), '0);
  endtask

  task automatic accept(input vec_t v);
    bus.plaintext = v.pt; bus.key = v.key; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic give_rnd(input vec_t v);
    bus.rnd = v.rnd; bus.rnd_valid = 1'b1;
    tick();
    bus.rnd_valid = 1'b0;
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    logic [127:0] r;
    hs({tag, ".idle"}, 1, 0, 0, 0, 0);
    accept(v);
    hs({tag, ".wait"}, 0, 1, 0, 0, 1);
    give_rnd(v);
    hs({tag, ".send"}, 0, 0, 1, 0, 1);
    chk_shares(tag, v);
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    hs({tag, ".run"}, 0, 0, 0, 0, 1);
    chk({tag, ".zero_shp"}, bus.sh_plaintext, '0);
    chk({tag, ".zero_shk"}, bus.sh_key, '0);
    r = r128();
    bus.sh_ciphertext = ilv(r, v.ct ^ r); bus.core_cipher_valid = 1'b1;
    tick();
    bus.core_cipher_valid = 1'b0; bus.sh_ciphertext = '0;
    hs({tag, ".out"}, 0, 0, 0, 1, 1);
    chk({tag, ".ct"}, 256'(bus.ciphertext), 256'(v.ct));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    hs({tag, ".done"}, 1, 0, 0, 0, 0);
    chk({tag, ".ct_hold"}, 256'(bus.ciphertext), 256'(v.ct));
  endtask

  initial begin
    logic [127:0] r;
    vt[0] = '{pt: PT, key: KEY, rnd: '0,
              pe: '0, po: PT, ke: '0, ko: KEY, ct: CT0};
    vt[1] = '{pt: PT, key: KEY, rnd: '1,
              pe: '1, po: 128'hffeeddccbbaa99887766554433221100,
              ke: '1, ko: 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0,
              ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vt[2] = '{pt: PT, key: KEY, rnd: {{16{8'h55}}, {16{8'haa}}},
              pe: {16{8'haa}}, po: 128'haabb8899eeffccdd2233001166774455,
              ke: {16{8'h55}}, ko: 128'h55545756515053525d5c5f5e59585b5a,
              ct: CT0};

    bus.in_valid = 0; bus.plaintext = '0; bus.key = '0; bus.rnd_valid = 0; bus.rnd = '0;
    bus.core_ready = 0; bus.core_cipher_valid = 0; bus.sh_ciphertext = '0; bus.out_ready = 0;
    tick();
    do_reset("init");

    for (int k = 0; k < 3; k++) run_txn($sformatf("vec%0d", k), vt[k]);

    // stray strobes in IDLE: nothing moves, ciphertext kept
    bus.core_cipher_valid = 1; bus.rnd_valid = 1; bus.sh_ciphertext = '1; bus.rnd = '1;
    tick();
    bus.core_cipher_valid = 0; bus.rnd_valid = 0; bus.sh_ciphertext = '0;
    hs("stray_idle", 1, 0, 0, 0, 0);
    chk("stray_idle.ct", 256'(bus.ciphertext), 256'(CT0));

    // back-pressure, in_valid outside IDLE, stray cipher pulse in SEND
    accept(vt[2]);
    bus.in_valid = 1; bus.plaintext = ~PT; bus.key = ~KEY;
    for (int c = 0; c < 5; c++) begin
      tick();
      hs($sformatf("bp_rnd%0d", c), 0, 1, 0, 0, 1);
    end
    bus.in_valid = 0;
    give_rnd(vt[2]);
    for (int c = 0; c < 3; c++) begin
      hs($sformatf("bp_core%0d", c), 0, 0, 1, 0, 1);
      chk_shares($sformatf("bp_core%0d", c), vt[2]);
      bus.core_cipher_valid = (c == 1); bus.sh_ciphertext = '1;
      tick();
      bus.core_cipher_valid = 0;
    end
    chk("stray_send.ct", 256'(bus.ciphertext), 256'(CT0));
    hs("bp_send_last", 0, 0, 1, 0, 1);
    bus.core_ready = 1;
    tick();
    bus.core_ready = 0;
    hs("bp_run", 0, 0, 0, 0, 1);
    // capture with out_ready already high: out_ready ignored in RUN
    r = r128();
    bus.sh_ciphertext = ilv(vt[1].ct ^ r, r); bus.core_cipher_valid = 1; bus.out_ready = 1;
    tick();
    bus.core_cipher_valid = 0; bus.out_ready = 0; bus.sh_ciphertext = '0;
    for (int c = 0; c < 4; c++) begin
      hs($sformatf("bp_out%0d", c), 0, 0, 0, 1, 1);
      chk($sformatf("bp_out%0d.ct", c), 256'(bus.ciphertext), 256'(vt[1].ct));
      tick();
    end
    bus.out_ready = 1;
    tick();
    bus.out_ready = 0;
    hs("bp_done", 1, 0, 0, 0, 0);

    // reset mid-operation in SEND, RUN and OUT
    accept(vt[1]); give_rnd(vt[1]);
    hs("pre_rst_send", 0, 0, 1, 0, 1);
    do_reset("rst_send");
    accept(vt[1]); give_rnd(vt[1]);
    bus.core_ready = 1; tick(); bus.core_ready = 0;
    hs("pre_rst_run", 0, 0, 0, 0, 1);
    do_reset("rst_run");
    accept(vt[0]); give_rnd(vt[0]);
    bus.core_ready = 1; tick(); bus.core_ready = 0;
    r = r128();
    bus.sh_ciphertext = ilv(r, vt[1].ct ^ r); bus.core_cipher_valid = 1;
    tick();
    bus.core_cipher_valid = 0;
    chk("pre_rst_out.ct", 256'(bus.ciphertext), 256'(vt[1].ct));
    do_reset("rst_out");
    run_txn("post_rst", vt[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
